// File: rtl/pe_cfg_if.sv
// Configuration port bundle for the simple PE tile: command/address word,
// direct-write data and strobes from the host, read data and completion
// pulse back from the PE.
interface pe_cfg_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_we;
    logic              cfg_en;
    logic [DATA_W-1:0] cfg_rdata;
    logic              intr;

    // Host side drives commands and observes results.
    modport master (
        output cfg_addr,
        output cfg_wdata,
        output cfg_we,
        output cfg_en,
        input  cfg_rdata,
        input  intr
    );

    // PE side consumes commands and returns results.
    modport slave (
        input  cfg_addr,
        input  cfg_wdata,
        input  cfg_we,
        input  cfg_en,
        output cfg_rdata,
        output intr
    );
endinterface

// File: rtl/pe_top_simple.sv
// Simple PE tile: 32x32 register file with R0 hard-wired to zero, loaded by
// direct writes and updated by single-cycle ALU commands encoded in the
// address word. Read port is combinational; intr pulses once per executed op.
// Optional feature macro: PE_MAC_EN enables func 12 (rs1*rs2 + R[rs3]).
module pe_top_simple (
    input  logic     clk,
    input  logic     rst,
    pe_cfg_if.slave  cfg
);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned CLASS_W   = 7;
    localparam int unsigned FUNC_W    = 5;

    localparam logic [CLASS_W-1:0] CLASS_ALU = 7'd1;

    localparam logic [FUNC_W-1:0] FN_ADD = 5'd1;
    localparam logic [FUNC_W-1:0] FN_SUB = 5'd2;
    localparam logic [FUNC_W-1:0] FN_MUL = 5'd3;
    localparam logic [FUNC_W-1:0] FN_AND = 5'd4;
    localparam logic [FUNC_W-1:0] FN_OR  = 5'd5;
    localparam logic [FUNC_W-1:0] FN_XOR = 5'd6;
    localparam logic [FUNC_W-1:0] FN_SLL = 5'd7;
    localparam logic [FUNC_W-1:0] FN_SRL = 5'd8;
    localparam logic [FUNC_W-1:0] FN_SRA = 5'd9;
    localparam logic [FUNC_W-1:0] FN_MAX = 5'd10;
    localparam logic [FUNC_W-1:0] FN_MIN = 5'd11;
`ifdef PE_MAC_EN
    localparam logic [FUNC_W-1:0] FN_MAC = 5'd12;
`endif

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic              intr_q;
    logic              intr_d;

    logic [CLASS_W-1:0] cls_c;
    logic [FUNC_W-1:0]  func_c;
    logic [IDX_W-1:0]   rs1_c;
    logic [IDX_W-1:0]   rs2_c;
    logic [IDX_W-1:0]   rd_c;
    logic [DATA_W-1:0]  op_a_c;
    logic [DATA_W-1:0]  op_b_c;
    logic [DATA_W-1:0]  alu_res_c;
    logic               alu_ok_c;
    logic               exec_c;
    logic               wr_en_c;
    logic [DATA_W-1:0]  wr_data_c;
`ifdef PE_MAC_EN
    logic [IDX_W-1:0]   rs3_c;
    logic [DATA_W-1:0]  op_c_c;
`else
    logic               unused_rs3_c;
`endif

    // R0 always reads as zero regardless of what its storage holds.
    function automatic logic [DATA_W-1:0] rf_read(input logic [IDX_W-1:0] idx);
        if (idx == '0) begin
            return '0;
        end
        return rf_q[idx];
    endfunction

    // Command word field split.
    always_comb begin
        cls_c  = cfg.cfg_addr[31:25];
        func_c = cfg.cfg_addr[24:20];
        rs1_c  = cfg.cfg_addr[19:15];
        rs2_c  = cfg.cfg_addr[14:10];
        rd_c   = cfg.cfg_addr[4:0];
    end

`ifdef PE_MAC_EN
    // Accumulator operand only exists when the MAC datapath is built.
    always_comb begin
        rs3_c  = cfg.cfg_addr[9:5];
        op_c_c = rf_read(rs3_c);
    end
`else
    // rs3 field has no consumer without the MAC datapath.
    assign unused_rs3_c = ^cfg.cfg_addr[9:5];
`endif

    // Operand fetch from pre-edge register contents (rs == rd sees old value).
    always_comb begin
        op_a_c = rf_read(rs1_c);
        op_b_c = rf_read(rs2_c);
    end

    // Single-cycle ALU; alu_ok_c flags a func code that produces a result.
    always_comb begin
        alu_res_c = '0;
        alu_ok_c  = 1'b1;
        case (func_c)
            FN_ADD: alu_res_c = op_a_c + op_b_c;
            FN_SUB: alu_res_c = op_a_c - op_b_c;
            FN_MUL: alu_res_c = op_a_c * op_b_c;
            FN_AND: alu_res_c = op_a_c & op_b_c;
            FN_OR:  alu_res_c = op_a_c | op_b_c;
            FN_XOR: alu_res_c = op_a_c ^ op_b_c;
            FN_SLL: alu_res_c = op_a_c << op_b_c[IDX_W-1:0];
            FN_SRL: alu_res_c = op_a_c >> op_b_c[IDX_W-1:0];
            FN_SRA: alu_res_c = DATA_W'($signed(op_a_c) >>> op_b_c[IDX_W-1:0]);
            FN_MAX: alu_res_c = ($signed(op_a_c) > $signed(op_b_c)) ? op_a_c : op_b_c;
            FN_MIN: alu_res_c = ($signed(op_a_c) < $signed(op_b_c)) ? op_a_c : op_b_c;
`ifdef PE_MAC_EN
            FN_MAC: alu_res_c = (op_a_c * op_b_c) + op_c_c;
`endif
            default: alu_ok_c = 1'b0;
        endcase
    end

    // Command arbitration: execute wins over direct write in the same cycle.
    always_comb begin
        exec_c    = cfg.cfg_en && (cls_c == CLASS_ALU) && alu_ok_c;
        wr_en_c   = 1'b0;
        wr_data_c = cfg.cfg_wdata;
        if (cfg.cfg_en) begin
            wr_en_c   = exec_c;
            wr_data_c = alu_res_c;
        end else if (cfg.cfg_we) begin
            wr_en_c   = 1'b1;
        end
        intr_d = exec_c;
    end

    // Register file and completion pulse; reset drops any concurrent command.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            intr_q <= 1'b0;
        end else begin
            if (wr_en_c && (rd_c != '0)) begin
                rf_q[rd_c] <= wr_data_c;
            end
            intr_q <= intr_d;
        end
    end

    // Combinational read port and registered interrupt.
    assign cfg.cfg_rdata = rf_read(cfg.cfg_addr[4:0]);
    assign cfg.intr      = intr_q;

endmodule

// File: tb/tb_pe_top_simple.sv
// Self-checking bench for pe_top_simple: table of command vectors with
// expected post-edge read data and intr, checked through a scoreboard queue.
module tb_pe_top_simple;
    logic clk;
    logic rst;

    pe_cfg_if cfg_bus ();

    pe_top_simple dut (
        .clk (clk),
        .rst (rst),
        .cfg (cfg_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        en;
        logic [31:0] exp_data;
        logic        exp_intr;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp_data;
        logic        exp_intr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    function automatic logic [31:0] cmd(input logic [6:0] cls, input logic [4:0] fn,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rs3, input logic [4:0] rd);
        return {cls, fn, rs1, rs2, rs3, rd};
    endfunction

    function automatic void add(input string nm, input logic [31:0] a, input logic [31:0] wd,
                                input logic we, input logic en,
                                input logic [31:0] ed, input logic ei);
        vec_t v;
        v.name = nm; v.addr = a; v.wdata = wd; v.we = we; v.en = en;
        v.exp_data = ed; v.exp_intr = ei;
        vecs.push_back(v);
    endfunction

    // Drive one command before the edge, check R[rd] and intr just after it.
    task automatic step(input string nm, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic en, input logic r,
                        input logic [31:0] ed, input logic ei);
        exp_t e;
        @(negedge clk);
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_wdata = wd;
        cfg_bus.cfg_we    = we;
        cfg_bus.cfg_en    = en;
        rst               = r;
        e.name = nm; e.exp_data = ed; e.exp_intr = ei;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (cfg_bus.cfg_rdata !== e.exp_data) begin
                n_fail++;
                $display("FAIL %s rdata: got %h want %h", e.name, cfg_bus.cfg_rdata, e.exp_data);
            end
            n_checks++;
            if (cfg_bus.intr !== e.exp_intr) begin
                n_fail++;
                $display("FAIL %s intr: got %b want %b", e.name, cfg_bus.intr, e.exp_intr);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Vector table: each entry's address low bits select the register
        // whose post-edge value is checked.
        add("wr_r1",      32'd1, 32'd10, 1'b1, 1'b0, 32'd10, 1'b0);
        add("wr_r2",      32'd2, 32'd20, 1'b1, 1'b0, 32'd20, 1'b0);
        add("add_r4",     cmd(7'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd4), 32'd0, 1'b0, 1'b1, 32'd30, 1'b1);
        add("sub_r5",     cmd(7'd1, 5'd2, 5'd1, 5'd2, 5'd0, 5'd5), 32'd0, 1'b0, 1'b1, 32'hFFFF_FFF6, 1'b1);
        add("mul_r6",     cmd(7'd1, 5'd3, 5'd1, 5'd2, 5'd0, 5'd6), 32'd0, 1'b0, 1'b1, 32'd200, 1'b1);
        add("rd_r4",      32'd4, 32'd0, 1'b0, 1'b0, 32'd30, 1'b0);
        add("wr_r0",      32'd0, 32'd123, 1'b1, 1'b0, 32'd0, 1'b0);
        add("exec_r0",    cmd(7'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd0), 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
        add("func31",     cmd(7'd1, 5'd31, 5'd1, 5'd2, 5'd0, 5'd4), 32'd0, 1'b0, 1'b1, 32'd30, 1'b0);
        add("class2",     cmd(7'd2, 5'd1, 5'd1, 5'd2, 5'd0, 5'd4), 32'd0, 1'b0, 1'b1, 32'd30, 1'b0);
        add("func0",      cmd(7'd1, 5'd0, 5'd1, 5'd2, 5'd0, 5'd4), 32'd0, 1'b0, 1'b1, 32'd30, 1'b0);
        add("exec_ign_we", cmd(7'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd8), 32'd777, 1'b1, 1'b1, 32'd30, 1'b1);
        add("wr_r3",      32'd3, 32'd5, 1'b1, 1'b0, 32'd5, 1'b0);
`ifdef PE_MAC_EN
        add("mac_r9",     cmd(7'd1, 5'd12, 5'd1, 5'd2, 5'd3, 5'd9), 32'd0, 1'b0, 1'b1, 32'd205, 1'b1);
`else
        add("mac_r9",     cmd(7'd1, 5'd12, 5'd1, 5'd2, 5'd3, 5'd9), 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
`endif
        add("wr_r10",     32'd10, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0);
        add("wr_r11",     32'd11, 32'd4, 1'b1, 1'b0, 32'd4, 1'b0);
        add("sra_r12",    cmd(7'd1, 5'd9, 5'd10, 5'd11, 5'd0, 5'd12), 32'd0, 1'b0, 1'b1, 32'hF800_0000, 1'b1);
        add("srl_r13",    cmd(7'd1, 5'd8, 5'd10, 5'd11, 5'd0, 5'd13), 32'd0, 1'b0, 1'b1, 32'h0800_0000, 1'b1);
        add("sll_r14",    cmd(7'd1, 5'd7, 5'd11, 5'd11, 5'd0, 5'd14), 32'd0, 1'b0, 1'b1, 32'd64, 1'b1);
        add("wr_r15",     32'd15, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        add("wr_r16",     32'd16, 32'd1, 1'b1, 1'b0, 32'd1, 1'b0);
        add("max_r17",    cmd(7'd1, 5'd10, 5'd15, 5'd16, 5'd0, 5'd17), 32'd0, 1'b0, 1'b1, 32'd1, 1'b1);
        add("min_r18",    cmd(7'd1, 5'd11, 5'd15, 5'd16, 5'd0, 5'd18), 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        add("and_r19",    cmd(7'd1, 5'd4, 5'd1, 5'd4, 5'd0, 5'd19), 32'd0, 1'b0, 1'b1, 32'd10, 1'b1);
        add("or_r20",     cmd(7'd1, 5'd5, 5'd1, 5'd2, 5'd0, 5'd20), 32'd0, 1'b0, 1'b1, 32'd30, 1'b1);
        add("xor_r21",    cmd(7'd1, 5'd6, 5'd1, 5'd4, 5'd0, 5'd21), 32'd0, 1'b0, 1'b1, 32'd20, 1'b1);
        add("add_self",   cmd(7'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1), 32'd0, 1'b0, 1'b1, 32'd20, 1'b1);
        add("rd_r1",      32'd1, 32'd0, 1'b0, 1'b0, 32'd20, 1'b0);
        add("rd_r5",      32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFF6, 1'b0);
        add("rd_r0",      32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_wdata = '0;
        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_en    = 1'b0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state: every register reads zero, no interrupt.
        for (int i = 0; i < 32; i++) begin
            step($sformatf("rst_r%0d", i), 32'(i), 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].en, 1'b0,
                 vecs[i].exp_data, vecs[i].exp_intr);
        end

        // Reset concurrent with an execute: operation dropped, state cleared.
        step("wr_r7_pre", 32'd7, 32'd55, 1'b1, 1'b0, 1'b0, 32'd55, 1'b0);
        step("rst_exec",  cmd(7'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd7), 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
        step("post_rst_r7", 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step("post_rst_r1", 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Single execute after reset: intr high one cycle, then low.
        step("wr_r2_b",   32'd2, 32'd7, 1'b1, 1'b0, 1'b0, 32'd7, 1'b0);
        step("add_r3_b",  cmd(7'd1, 5'd1, 5'd2, 5'd2, 5'd0, 5'd3), 32'd0, 1'b0, 1'b1, 1'b0, 32'd14, 1'b1);
        step("idle_r3_b", 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 32'd14, 1'b0);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
